// File: rtl/reg_scoreboard_pkg.sv
// Shared register-file definitions used by the issue/writeback scoreboard.
package reg_scoreboard_pkg;

    localparam int RF_XLEN    = 32;
    localparam int RF_NREG    = 32;
    localparam int RF_AW      = 5;
    localparam int SB_N_ISSUE = 2;
    localparam int SB_N_WB    = 2;
    localparam int SB_N_SRC   = 4;

    function automatic logic [1:0] hit_cnt(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// One per-register pending-write counter: adds issue hits, subtracts
// writeback hits, saturates at zero and flags the underflow.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [1:0]       inc,
    input  logic [1:0]       dec,
    output logic [CNT_W-1:0] cnt_q,
    output logic             underflow
);

    logic [CNT_W+1:0] sum;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        sum       = (CNT_W+2)'(cnt_q) + (CNT_W+2)'(inc);
        underflow = 1'b0;
        cnt_d     = CNT_W'(sum - (CNT_W+2)'(dec));
        if (flush) begin
            cnt_d = '0;
        end else if (sum < (CNT_W+2)'(dec)) begin
            underflow = 1'b1;
            cnt_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: per-register outstanding write counts
// driving source-busy lookups for a dual-issue pipeline.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W = 2,
    parameter int NREG  = RF_NREG
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   flush,
    input  logic [SB_N_SRC-1:0][RF_AW-1:0]         src_addr,
    output logic [SB_N_SRC-1:0]                    src_busy,
    input  logic [SB_N_ISSUE-1:0]                  issue_valid,
    input  logic [SB_N_ISSUE-1:0]                  issue_we,
    input  logic [SB_N_ISSUE-1:0][RF_AW-1:0]       issue_dst,
    output logic                                   issue_ready,
    input  logic [SB_N_WB-1:0]                     wb_valid,
    input  logic [SB_N_WB-1:0][RF_AW-1:0]          wb_addr,
    output logic [NREG-1:0]                        busy_mask,
    output logic                                   err_underflow
);

    localparam int CMAX = (2 ** CNT_W) - 1;

    logic [CNT_W-1:0]      cnt [NREG];
    logic [NREG-1:0]       uf;
    logic [SB_N_ISSUE-1:0] iss_hit;
    logic [SB_N_WB-1:0]    wb_hit;
    logic [SB_N_ISSUE-1:0] over;
    logic [CNT_W+1:0]      tot;
    logic                  err_q;
    logic                  err_d;

    always_comb begin
        for (int k = 0; k < SB_N_ISSUE; k++) begin
            iss_hit[k] = issue_valid[k] & issue_we[k]
                       & (issue_dst[k] != '0);
        end
        for (int k = 0; k < SB_N_WB; k++) begin
            wb_hit[k] = wb_valid[k] & (wb_addr[k] != '0);
        end
    end

    // Headroom is judged before writeback credit, so a same-cycle
    // retire never lets an otherwise overflowing issue through.
    always_comb begin
        over = '0;
        tot  = '0;
        for (int k = 0; k < SB_N_ISSUE; k++) begin
            tot = (CNT_W+2)'(cnt[issue_dst[k]]);
            for (int j = 0; j < SB_N_ISSUE; j++) begin
                if (iss_hit[j] && (issue_dst[j] == issue_dst[k])) begin
                    tot = tot + 1'b1;
                end
            end
            over[k] = iss_hit[k] && (tot > (CNT_W+2)'(CMAX));
        end
        issue_ready = ~|over;
    end

    assign cnt[0] = '0;
    assign uf[0]  = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        logic [1:0] inc;
        logic [1:0] dec;

        assign inc = hit_cnt(
            issue_ready & iss_hit[0] & (issue_dst[0] == RF_AW'(r)),
            issue_ready & iss_hit[1] & (issue_dst[1] == RF_AW'(r)));
        assign dec = hit_cnt(
            wb_hit[0] & (wb_addr[0] == RF_AW'(r)),
            wb_hit[1] & (wb_addr[1] == RF_AW'(r)));

        sb_counter #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .inc      (inc),
            .dec      (dec),
            .cnt_q    (cnt[r]),
            .underflow(uf[r])
        );
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy_mask[r] = |cnt[r];
        end
        for (int i = 0; i < SB_N_SRC; i++) begin
            src_busy[i] = busy_mask[src_addr[i]];
        end
    end

    assign err_d         = err_q | (|uf);
    assign err_underflow = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized and directed checks of reg_scoreboard against a counting model.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic                            clk = 1'b0;
    logic                            reset;
    logic                            flush;
    logic [SB_N_SRC-1:0][RF_AW-1:0]  src_addr;
    logic [SB_N_SRC-1:0]             src_busy;
    logic [1:0]                      issue_valid;
    logic [1:0]                      issue_we;
    logic [1:0][RF_AW-1:0]           issue_dst;
    logic                            issue_ready;
    logic [1:0]                      wb_valid;
    logic [1:0][RF_AW-1:0]           wb_addr;
    logic [31:0]                     busy_mask;
    logic                            err_underflow;

    int m_cnt [32];
    bit m_err;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.CNT_W(2), .NREG(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .src_addr     (src_addr),
        .src_busy     (src_busy),
        .issue_valid  (issue_valid),
        .issue_we     (issue_we),
        .issue_dst    (issue_dst),
        .issue_ready  (issue_ready),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .busy_mask    (busy_mask),
        .err_underflow(err_underflow)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit writes(int k);
        return issue_valid[k] && issue_we[k] && issue_dst[k] != 0;
    endfunction

    function automatic bit model_ready();
        for (int k = 0; k < 2; k++) begin
            if (writes(k)) begin
                int hits = 0;
                for (int j = 0; j < 2; j++)
                    if (writes(j) && issue_dst[j] == issue_dst[k]) hits++;
                if (m_cnt[issue_dst[k]] + hits > 3) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    task automatic idle();
        reset       = 1'b0;
        flush       = 1'b0;
        issue_valid = '0;
        issue_we    = '0;
        issue_dst   = '0;
        wb_valid    = '0;
        wb_addr     = '0;
    endtask

    task automatic cycle();
        bit          rdy;
        int          nxt [32];
        bit          nerr;
        logic [31:0] bm;
        logic [3:0]  sb;
        rdy = model_ready();
        #1;
        check("issue_ready", {31'b0, issue_ready}, {31'b0, rdy});
        nerr = m_err;
        for (int r = 0; r < 32; r++) begin
            int v = m_cnt[r];
            if (r != 0) begin
                for (int k = 0; k < 2; k++) begin
                    if (rdy && writes(k) && issue_dst[k] == r) v++;
                    if (wb_valid[k] && wb_addr[k] == r) v--;
                end
            end
            if (v < 0) begin
                v    = 0;
                nerr = 1'b1;
            end
            if (flush) v = 0;
            nxt[r] = v;
        end
        if (flush) nerr = m_err;
        if (reset) begin
            nerr = 1'b0;
            for (int r = 0; r < 32; r++) nxt[r] = 0;
        end
        m_cnt = nxt;
        m_err = nerr;
        @(posedge clk);
        #1;
        bm = '0;
        for (int r = 1; r < 32; r++) bm[r] = (m_cnt[r] != 0);
        for (int i = 0; i < 4; i++) sb[i] = bm[src_addr[i]];
        check("busy_mask", busy_mask, bm);
        check("src_busy", {28'b0, src_busy}, {28'b0, sb});
        check("err_underflow", {31'b0, err_underflow}, {31'b0, m_err});
    endtask

    task automatic issue1(input logic [4:0] d);
        idle();
        issue_valid  = 2'b01;
        issue_we     = 2'b01;
        issue_dst[0] = d;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_err    = 1'b0;
        src_addr = '0;
        idle();
        reset = 1'b1;
        cycle();
        check("rst_ready", {31'b0, issue_ready}, 32'd1);

        src_addr[0] = 5'd5;
        issue1(5'd5);
        cycle();
        check("busy5_t1", {31'b0, src_busy[0]}, 32'd1);
        idle();
        cycle();
        cycle();
        wb_valid   = 2'b10;
        wb_addr[1] = 5'd5;
        cycle();
        check("busy5_clr", {31'b0, src_busy[0]}, 32'd0);

        idle();
        issue_valid = 2'b11;
        issue_we    = 2'b11;
        issue_dst   = {5'd7, 5'd7};
        cycle();
        idle();
        wb_valid   = 2'b01;
        wb_addr[0] = 5'd7;
        cycle();
        check("busy7_one", {31'b0, busy_mask[7]}, 32'd1);
        cycle();
        check("busy7_clr", {31'b0, busy_mask[7]}, 32'd0);

        issue1(5'd9);
        cycle();
        issue1(5'd9);
        wb_valid   = 2'b01;
        wb_addr[0] = 5'd9;
        cycle();
        check("busy9_cancel", {31'b0, busy_mask[9]}, 32'd1);

        for (int i = 0; i < 3; i++) begin
            issue1(5'd3);
            cycle();
        end
        idle();
        issue_valid = 2'b11;
        issue_we    = 2'b11;
        issue_dst   = {5'd3, 5'd3};
        #1;
        check("full_ready", {31'b0, issue_ready}, 32'd0);
        cycle();
        wb_valid   = 2'b01;
        wb_addr[0] = 5'd3;
        #1;
        check("full_wb_ready", {31'b0, issue_ready}, 32'd0);
        cycle();

        idle();
        src_addr = '0;
        issue1(5'd0);
        cycle();
        idle();
        wb_valid   = 2'b10;
        wb_addr[1] = 5'd12;
        cycle();
        check("uf_set", {31'b0, err_underflow}, 32'd1);
        idle();
        flush = 1'b1;
        cycle();
        check("uf_hold", {31'b0, err_underflow}, 32'd1);
        idle();
        reset = 1'b1;
        cycle();
        check("uf_rst", {31'b0, err_underflow}, 32'd0);

        idle();
        issue_valid = 2'b11;
        issue_we    = 2'b11;
        issue_dst   = {5'd8, 5'd4};
        cycle();
        issue1(5'd9);
        cycle();
        issue1(5'd10);
        flush = 1'b1;
        cycle();
        check("flush_mask", busy_mask, 32'd0);

        for (int n = 0; n < 500; n++) begin
            idle();
            for (int i = 0; i < 4; i++)
                src_addr[i] = 5'($urandom_range(0, 7));
            issue_valid = 2'($urandom);
            issue_we    = 2'($urandom);
            wb_valid    = 2'($urandom_range(0, 3)) & 2'($urandom);
            for (int k = 0; k < 2; k++) begin
                issue_dst[k] = 5'($urandom_range(0, 7));
                wb_addr[k]   = 5'($urandom_range(0, 7));
            end
            flush = ($urandom_range(0, 24) == 0);
            reset = ($urandom_range(0, 79) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL have parameter CNT_W, default 2, the width of each per-register pending-write counter.
REQ-002 The block SHALL have parameter NREG, default 32, the number of architectural registers.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  reset, synchronous and active-high.
REQ-005 Port flush  input  1  pipeline flush; discards all pending-write tracking.
REQ-006 Port src_addr  input  4x5  the source register numbers checked by the issue stage, packed [3:0][4:0].
REQ-007 Port src_busy  output  4  src_busy[i]=1 means src_addr[i] has an outstanding write.
REQ-008 Port issue_valid  input  2  issue slot k is issuing an instruction this cycle.
REQ-009 Port issue_we  input  2  issue slot k writes a destination register.
REQ-010 Port issue_dst  input  2x5  destination register number of slot k.
REQ-011 Port issue_ready  output  1  the scoreboard can accept this cycle's issue.
REQ-012 Port wb_valid  input  2  writeback port k retires one write this cycle (the same strobes as the regfile we1/we2).
REQ-013 Port wb_addr  input  2x5  register number retired on port k.
REQ-014 Port busy_mask  output  NREG  bit r=1 when register r has a nonzero counter.
REQ-015 Port err_underflow  output  1  sticky flag: a writeback hit a zero counter.

Function
REQ-016 The block SHALL keep one CNT_W-bit counter per register; counter r = issued minus retired writes to r.
REQ-017 Register 0 SHALL never be tracked: its counter stays 0, its busy_mask bit is 0, and its src_busy is 0; issues and writebacks to r0 are ignored.
REQ-018 An issue increment SHALL apply to slot k only when issue_valid[k] & issue_we[k] & issue_ready & issue_dst[k]!=0.
REQ-019 A writeback decrement SHALL apply to port k only when wb_valid[k] & wb_addr[k]!=0.
REQ-020 The next counter value SHALL be counter + (issue hits, 0..2) - (wb hits, 0..2), all applied in one cycle. Both slots naming the same register count +2; both ports naming the same register count -2.
REQ-021 An issue and a writeback to the same register in the same cycle SHALL cancel, leaving the counter unchanged.
REQ-022 src_busy and busy_mask SHALL be decoded combinationally from the registered counters only. A writeback in cycle t clears busy at t+1, matching regfile write timing; there is no same-cycle bypass.
REQ-023 issue_ready SHALL be 0 when, for any valid writing slot, the counter plus that cycle's issue hits to the same register, before writeback credit, would exceed 2^CNT_W-1. Otherwise it SHALL be 1.
REQ-024 issue_ready SHALL NOT depend on src_busy; hazard stalling is decided by the issue stage.
REQ-025 A decrement that would take a counter below 0 SHALL saturate it at 0 and set err_underflow, which then holds until reset.
REQ-026 flush SHALL zero all counters on the next edge and SHALL take priority over same-cycle issue and writeback. err_underflow is unaffected by flush.
REQ-027 Latency: an issue at cycle t SHALL make src_busy visible at t+1.

Reset
REQ-028 On reset, all counters SHALL be 0; busy_mask=0, src_busy=0, issue_ready=1, err_underflow=0.
REQ-029 reset SHALL dominate flush, issue and writeback in the same cycle. Reset mid-operation discards all outstanding tracking without reporting underflow.

Structure
REQ-030 NREG, the register-address width (5) and the issue/writeback port counts (2) SHALL live in the shared definitions package alongside the existing regfile constants.
REQ-031 The per-register counter with its inc/dec/saturate logic SHALL be one sub-module, sb_counter, instantiated NREG-1 times.
REQ-032 Counter updates SHALL be a single clocked process; all outputs derive from registered state, except issue_ready, which is combinational on the issue inputs.

Verification
REQ-033 Issue slot0 dst=5 at cycle 1; src_addr[0]=5 -> src_busy[0]=1 from cycle 2; wb port1 addr=5 at cycle 4 -> src_busy[0]=0 at cycle 5.
REQ-034 Both slots issue dst=7 in one cycle -> counter 2; one wb to 7 -> still busy; second wb -> clear next cycle.
REQ-035 Same cycle: issue dst=9 and wb addr=9 with counter=1 -> counter stays 1 and busy remains.
REQ-036 CNT_W=2: three issues to r3, then a dual issue to r3 -> issue_ready=0 and counter stays 3; a wb to r3 in that cycle -> still 0 (credit not applied).
REQ-037 Issue dst=0 and src_addr=0 -> no counter change, src_busy=0; wb to r12 at counter 0 -> err_underflow=1, held through flush, cleared only by reset.
REQ-038 Registers 4, 8 and 9 busy, then flush asserted with a concurrent issue to r10 -> next cycle busy_mask=0.
